// File: rtl/exu_alu_ctrl_pkg.sv
// Shared types, encodings and constants for the EXU ALU controller.
// Holds the op encoding, FSM state encoding, datapath width and the JALR target mask.
package exu_alu_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_LUI  = 2'b01,
    OP_JAL  = 2'b10,
    OP_JALR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_TGT  = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Clears bit 0 of a JALR target.
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] LINK_OFS  = XLEN'(4);

  // Operands captured at issue and held for the whole operation.
  typedef struct packed {
    op_e               op;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   imm;
    logic [RIDX_W-1:0] rd;
  } issue_t;

  function automatic logic op_is_jump(input op_e op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic [XLEN-1:0] tgt_mask(input op_e op);
    return (op == OP_JALR) ? JALR_MASK : {XLEN{1'b1}};
  endfunction

endpackage

// File: rtl/exu_alu_ctrl_if.sv
// Issue, shared-datapath request and writeback signals of the EXU ALU controller.
// The slave modport is the controller; master is the decode/datapath/writeback side.
interface exu_alu_ctrl_if;
  import exu_alu_ctrl_pkg::*;

  logic                i_valid;
  logic                i_ready;
  logic [1:0]          i_op;
  logic [XLEN-1:0]     i_pc;
  logic [XLEN-1:0]     i_rs1;
  logic [XLEN-1:0]     i_op2;
  logic [XLEN-1:0]     i_imm;
  logic [RIDX_W-1:0]   i_rd;
  logic                i_flush;

  logic                alu_req_alu;
  logic                alu_req_alu_add;
  logic                alu_req_alu_lui;
  logic [XLEN-1:0]     alu_req_alu_op1;
  logic [XLEN-1:0]     alu_req_alu_op2;
  logic [XLEN-1:0]     alu_req_alu_res;

  logic                bjp_req_alu;
  logic                bjp_req_alu_add;
  logic [XLEN-1:0]     bjp_req_alu_op1;
  logic [XLEN-1:0]     bjp_req_alu_op2;
  logic [XLEN-1:0]     bjp_req_alu_add_res;

  logic                o_valid;
  logic                o_ready;
  logic [RIDX_W-1:0]   o_rd;
  logic                o_wen;
  logic [XLEN-1:0]     o_wdata;
  logic                o_jmp;
  logic [XLEN-1:0]     o_jmp_tgt;

  modport slave (
    input  i_valid, i_op, i_pc, i_rs1, i_op2, i_imm, i_rd, i_flush,
    input  alu_req_alu_res, bjp_req_alu_add_res, o_ready,
    output i_ready,
    output alu_req_alu, alu_req_alu_add, alu_req_alu_lui, alu_req_alu_op1, alu_req_alu_op2,
    output bjp_req_alu, bjp_req_alu_add, bjp_req_alu_op1, bjp_req_alu_op2,
    output o_valid, o_rd, o_wen, o_wdata, o_jmp, o_jmp_tgt
  );

  modport master (
    output i_valid, i_op, i_pc, i_rs1, i_op2, i_imm, i_rd, i_flush,
    output alu_req_alu_res, bjp_req_alu_add_res, o_ready,
    input  i_ready,
    input  alu_req_alu, alu_req_alu_add, alu_req_alu_lui, alu_req_alu_op1, alu_req_alu_op2,
    input  bjp_req_alu, bjp_req_alu_add, bjp_req_alu_op1, bjp_req_alu_op2,
    input  o_valid, o_rd, o_wen, o_wdata, o_jmp, o_jmp_tgt
  );

endinterface

// File: rtl/exu_alu_ctrl.sv
// EXU ALU controller: sequences ADD/LUI/JAL/JALR through the shared ALU and BJP adder
// ports and presents a registered writeback/redirect payload.
module exu_alu_ctrl
  import exu_alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  exu_alu_ctrl_if.slave bus
);

  state_e          state;
  state_e          state_nxt;
  issue_t          iss;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] jmp_tgt;
  logic            accept;
  logic            is_jump;

  assign is_jump = op_is_jump(iss.op);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and outputs; everything is forced low while reset is asserted
  always_comb begin
    state_nxt           = state;
    accept              = 1'b0;
    bus.i_ready         = 1'b0;
    bus.alu_req_alu     = 1'b0;
    bus.alu_req_alu_add = 1'b0;
    bus.alu_req_alu_lui = 1'b0;
    bus.alu_req_alu_op1 = '0;
    bus.alu_req_alu_op2 = '0;
    bus.bjp_req_alu     = 1'b0;
    bus.bjp_req_alu_add = 1'b0;
    bus.bjp_req_alu_op1 = '0;
    bus.bjp_req_alu_op2 = '0;
    bus.o_valid         = 1'b0;
    bus.o_rd            = '0;
    bus.o_wen           = 1'b0;
    bus.o_wdata         = '0;
    bus.o_jmp           = 1'b0;
    bus.o_jmp_tgt       = '0;
    if (rst_n) begin
      unique case (state)
        ST_IDLE: begin
          bus.i_ready = !bus.i_flush;
          if (bus.i_valid && !bus.i_flush) begin
            accept    = 1'b1;
            state_nxt = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_jump) begin
            // First BJP pass computes the link value
            bus.bjp_req_alu     = 1'b1;
            bus.bjp_req_alu_add = 1'b1;
            bus.bjp_req_alu_op1 = iss.pc;
            bus.bjp_req_alu_op2 = LINK_OFS;
          end else begin
            bus.alu_req_alu     = 1'b1;
            bus.alu_req_alu_add = (iss.op == OP_ADD);
            bus.alu_req_alu_lui = (iss.op == OP_LUI);
            bus.alu_req_alu_op1 = (iss.op == OP_ADD) ? iss.rs1 : '0;
            bus.alu_req_alu_op2 = iss.op2;
          end
          if (bus.i_flush)  state_nxt = ST_IDLE;
          else if (is_jump) state_nxt = ST_TGT;
          else              state_nxt = ST_RESP;
        end
        ST_TGT: begin
          // Second BJP pass computes the jump target
          bus.bjp_req_alu     = 1'b1;
          bus.bjp_req_alu_add = 1'b1;
          bus.bjp_req_alu_op1 = (iss.op == OP_JALR) ? iss.rs1 : iss.pc;
          bus.bjp_req_alu_op2 = iss.imm;
          state_nxt           = bus.i_flush ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          if (!bus.i_flush) begin
            bus.o_valid   = 1'b1;
            bus.o_rd      = iss.rd;
            bus.o_wen     = (iss.rd != '0);
            bus.o_wdata   = wdata;
            bus.o_jmp     = is_jump;
            bus.o_jmp_tgt = jmp_tgt;
          end
          if (bus.i_flush || bus.o_ready) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Operand capture and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss     <= '0;
      wdata   <= '0;
      jmp_tgt <= '0;
    end else begin
      if (accept) begin
        iss.op  <= op_e'(bus.i_op);
        iss.pc  <= bus.i_pc;
        iss.rs1 <= bus.i_rs1;
        iss.op2 <= bus.i_op2;
        iss.imm <= bus.i_imm;
        iss.rd  <= bus.i_rd;
        jmp_tgt <= '0;
      end
      if (state == ST_EXEC) begin
        wdata <= is_jump ? bus.bjp_req_alu_add_res : bus.alu_req_alu_res;
      end
      if (state == ST_TGT) begin
        jmp_tgt <= bus.bjp_req_alu_add_res & tgt_mask(iss.op);
      end
    end
  end

endmodule

// File: tb/tb_exu_alu_ctrl.sv
// Scoreboard bench for exu_alu_ctrl with a behavioural model of the shared ALU/BJP adders.
module tb_exu_alu_ctrl;
  import exu_alu_ctrl_pkg::*;

  typedef struct {
    op_e             op;
    logic [XLEN-1:0] pc, rs1, op2, imm;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata, tgt;
    logic            wen, jmp;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exu_alu_ctrl_if bus ();

  exu_alu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  // Shared datapath model
  assign bus.alu_req_alu_res     = bus.alu_req_alu_lui ? bus.alu_req_alu_op2
                                                       : bus.alu_req_alu_op1 + bus.alu_req_alu_op2;
  assign bus.bjp_req_alu_add_res = bus.bjp_req_alu_op1 + bus.bjp_req_alu_op2;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;
  int   n_alu = 0, n_bjp = 0;
  bit   seen = 1'b0;
  exp_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: protocol invariants, request operands, payload and latency
  always @(negedge clk) begin
    logic viol;
    exp_t e;
    if (!rst_n)
      check_eq("rst_outs", 64'(|{bus.i_ready, bus.alu_req_alu, bus.alu_req_alu_add,
               bus.alu_req_alu_lui, bus.alu_req_alu_op1, bus.alu_req_alu_op2, bus.bjp_req_alu,
               bus.bjp_req_alu_add, bus.bjp_req_alu_op1, bus.bjp_req_alu_op2, bus.o_valid,
               bus.o_rd, bus.o_wen, bus.o_wdata, bus.o_jmp, bus.o_jmp_tgt}), 0);
    check_eq("port_excl", 64'(bus.alu_req_alu & bus.bjp_req_alu), 0);
    viol = (!bus.alu_req_alu && (bus.alu_req_alu_add || bus.alu_req_alu_lui ||
            (|bus.alu_req_alu_op1) || (|bus.alu_req_alu_op2))) ||
           (!bus.bjp_req_alu && (bus.bjp_req_alu_add ||
            (|bus.bjp_req_alu_op1) || (|bus.bjp_req_alu_op2)));
    check_eq("idle_port_zero", 64'(viol), 0);

    if (exp_q.size() != 0) begin
      e = exp_q[0];
      if (bus.alu_req_alu) begin
        check_eq("alu_op1", bus.alu_req_alu_op1, (e.op == OP_ADD) ? e.rs1 : '0);
        check_eq("alu_op2", bus.alu_req_alu_op2, e.op2);
        check_eq("alu_add", bus.alu_req_alu_add, e.op == OP_ADD);
        check_eq("alu_lui", bus.alu_req_alu_lui, e.op == OP_LUI);
        n_alu++;
      end
      if (bus.bjp_req_alu) begin
        check_eq("bjp_add", bus.bjp_req_alu_add, 1);
        if (n_bjp == 0) begin
          check_eq("bjp_link_op1", bus.bjp_req_alu_op1, e.pc);
          check_eq("bjp_link_op2", bus.bjp_req_alu_op2, 4);
        end else begin
          check_eq("bjp_tgt_op1", bus.bjp_req_alu_op1, (e.op == OP_JALR) ? e.rs1 : e.pc);
          check_eq("bjp_tgt_op2", bus.bjp_req_alu_op2, e.imm);
        end
        n_bjp++;
      end
    end

    if (bus.o_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_valid", bus.o_valid, 0);
      end else begin
        e = exp_q[0];
        check_eq("o_rd", bus.o_rd, e.rd);
        check_eq("o_wen", bus.o_wen, e.wen);
        check_eq("o_wdata", bus.o_wdata, e.wdata);
        check_eq("o_jmp", bus.o_jmp, e.jmp);
        check_eq("o_jmp_tgt", bus.o_jmp_tgt, e.tgt);
        check_eq("irdy_in_resp", bus.i_ready, 0);
        if (!seen) check_eq("latency", 64'(cyc + 1 - acc_cyc), 64'(e.lat));
        seen = 1'b1;
        if (bus.o_ready) begin
          check_eq("n_alu_req", 64'(n_alu), e.jmp ? 0 : 1);
          check_eq("n_bjp_req", 64'(n_bjp), e.jmp ? 2 : 0);
          void'(exp_q.pop_front());
        end
      end
    end

    if (bus.i_valid && bus.i_ready) begin
      acc_cyc = cyc + 1;
      n_alu   = 0;
      n_bjp   = 0;
      seen    = 1'b0;
    end
  end

  task automatic issue(input op_e op, input logic [XLEN-1:0] pc, rs1, op2, imm,
                       input logic [4:0] rd, input bit push);
    exp_t e;
    int   n;
    e.op = op; e.pc = pc; e.rs1 = rs1; e.op2 = op2; e.imm = imm; e.rd = rd;
    case (op)
      OP_ADD:  e.wdata = rs1 + op2;
      OP_LUI:  e.wdata = op2;
      default: e.wdata = pc + XLEN'(4);
    endcase
    case (op)
      OP_JAL:  e.tgt = pc + imm;
      OP_JALR: e.tgt = (rs1 + imm) & ~XLEN'(1);
      default: e.tgt = '0;
    endcase
    e.wen = (rd != 5'd0);
    e.jmp = (op == OP_JAL) || (op == OP_JALR);
    e.lat = e.jmp ? 3 : 2;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.i_op = op; bus.i_pc = pc; bus.i_rs1 = rs1; bus.i_op2 = op2;
    bus.i_imm = imm; bus.i_rd = rd; bus.i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.i_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("issue_rdy", bus.i_ready, 1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_op = 2'b00; bus.i_pc = '0; bus.i_rs1 = '0;
    bus.i_op2 = '0; bus.i_imm = '0; bus.i_rd = '0; bus.i_flush = 1'b0; bus.o_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_irdy", bus.i_ready, 0);
    check_eq("rst_ovalid", bus.o_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_irdy", bus.i_ready, 1);

    issue(OP_ADD, 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd3, 1'b1);
    drain();
    issue(OP_LUI, 32'h0, 32'hDEAD_BEEF, 32'h1234_5000, 32'h0, 5'd0, 1'b1);
    drain();
    issue(OP_JALR, 32'h8000_0000, 32'h8000_1003, 32'h0, 32'h0, 5'd1, 1'b1);
    drain();

    // JAL with writeback stalled for 5 cycles
    bus.o_ready = 1'b0;
    issue(OP_JAL, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 5'd5, 1'b1);
    n = 0;
    while (!bus.o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_valid", bus.o_valid, 1);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("stall_hold", bus.o_valid, 1);
    end
    @(posedge clk); #1;
    bus.o_ready = 1'b1;
    drain();

    for (int k = 0; k < 16; k++)  begin
      issue(op_e'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'b1);
      drain();
    end

    // Flush in IDLE blocks the accept
    @(posedge clk); #1;
    bus.i_flush = 1'b1; bus.i_valid = 1'b1; bus.i_op = OP_ADD;
    @(negedge clk);
    check_eq("flush_idle_blk", bus.i_ready, 0);
    @(posedge clk); #1;
    bus.i_flush = 1'b0; bus.i_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_idle_after", bus.i_ready, 1);

    // Flush a JAL in TGT
    issue(OP_JAL, 32'h100, 32'h0, 32'h0, 32'h40, 5'd7, 1'b0);
    @(posedge clk); #1;
    bus.i_flush = 1'b1;
    @(negedge clk);
    check_eq("tgt_req", bus.bjp_req_alu, 1);
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    @(negedge clk);
    check_eq("flush_tgt_idle", bus.i_ready, 1);

    // Reset an ADD in EXEC
    issue(OP_ADD, 32'h0, 32'h5, 32'h6, 32'h0, 5'd9, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("exec_rst_req", bus.alu_req_alu, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("post_rst_irdy", bus.i_ready, 1);
      check_eq("post_rst_reqs", 64'({bus.alu_req_alu, bus.bjp_req_alu, bus.o_valid}), 0);
    end

    issue(OP_ADD, 32'h0, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd31, 1'b1);
    drain();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
